// File: rtl/tjmono_direct_pkg.sv
// Shared definitions for the TJ-Monopix2 direct-readout transmitter emulator.
package tjmono_direct_pkg;

  localparam int HIT_WIDTH = 32;

  // Hit word layout: {col[8:0], row[8:0], le[6:0], te[6:0]}
  localparam int COL_LSB = 23;
  localparam int ROW_LSB = 14;
  localparam int LE_LSB  = 7;
  localparam int TE_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FROZEN = 2'd1,
    SHIFT  = 2'd2
  } state_e;

endpackage

// File: rtl/tjmono_sync_fifo.sv
// First-word fall-through synchronous FIFO; rd_data always shows the head word.
module tjmono_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push;
  logic             pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Fullness is judged before any same-cycle pop, so a write while full is always lost.
  assign push = wr_en & ~full;
  assign pop  = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/tjmono_direct_tx_emu.sv
// Chip-side emulator of the TJ-Monopix2 token/freeze/read port: buffers hits and
// shifts one word out MSB first per accepted READ while frozen.
module tjmono_direct_tx_emu
  import tjmono_direct_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int HIT_WIDTH = tjmono_direct_pkg::HIT_WIDTH,
  parameter int CNT_WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RESETB,
  input  logic [HIT_WIDTH-1:0] HIT_DATA,
  input  logic                 HIT_WE,
  output logic                 HIT_FULL,
  output logic [CNT_WIDTH-1:0] HIT_DROP_CNT,
  input  logic                 FREEZE,
  input  logic                 READ,
  output logic                 TOKEN,
  output logic                 DATA,
  output logic                 BUSY,
  output logic [CNT_WIDTH-1:0] PROTO_ERR_CNT,
  output state_e               DBG_STATE
);

  // Handshake: READ is a one-cycle strobe honoured only in FROZEN with snapshot
  // words left; the word then appears on DATA for the next 32 cycles with BUSY high.

  state_e                 state_q, state_d;
  logic [AW:0]            frz_cnt_q, frz_cnt_d;
  logic [HIT_WIDTH-1:0]   shreg_q, shreg_d;
  logic [4:0]             bit_idx_q, bit_idx_d;
  logic                   data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   token_q, token_d;
  logic [CNT_WIDTH-1:0]   drop_cnt_q, perr_cnt_q;
  logic                   perr_inc;
  logic                   fifo_pop;
  logic [HIT_WIDTH-1:0]   fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [AW:0]            fifo_count;

  tjmono_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (HIT_WIDTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RESETB),
    .wr_en   (HIT_WE),
    .wr_data (HIT_DATA),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    frz_cnt_d = frz_cnt_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    data_d    = 1'b0;
    busy_d    = busy_q;
    token_d   = token_q;
    fifo_pop  = 1'b0;
    perr_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        token_d  = ~fifo_empty;
        perr_inc = READ;
        if (FREEZE) begin
          state_d   = FROZEN;
          frz_cnt_d = fifo_count;
        end
      end
      FROZEN: begin
        if (READ && (frz_cnt_q != '0)) begin
          fifo_pop  = 1'b1;
          shreg_d   = fifo_head;
          frz_cnt_d = frz_cnt_q - (AW+1)'(1);
          data_d    = fifo_head[HIT_WIDTH-1];
          busy_d    = 1'b1;
          bit_idx_d = 5'd31;
          state_d   = SHIFT;
        end else begin
          perr_inc = READ;
          if (!FREEZE) state_d = IDLE;
        end
        // Uses the post-pop count so TOKEN drops right after the last snapshot pop.
        token_d = (frz_cnt_d != '0);
      end
      SHIFT: begin
        perr_inc = READ;
        token_d  = (frz_cnt_q != '0);
        if (bit_idx_q == 5'd0) begin
          busy_d  = 1'b0;
          state_d = FREEZE ? FROZEN : IDLE;
        end else begin
          bit_idx_d = bit_idx_q - 5'd1;
          data_d    = shreg_q[bit_idx_q - 5'd1];
          busy_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      state_q    <= IDLE;
      frz_cnt_q  <= '0;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      data_q     <= 1'b0;
      busy_q     <= 1'b0;
      token_q    <= 1'b0;
      drop_cnt_q <= '0;
      perr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      frz_cnt_q <= frz_cnt_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      token_q   <= token_d;
      if (HIT_WE && fifo_full && (drop_cnt_q != '1))
        drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
      if (perr_inc && (perr_cnt_q != '1))
        perr_cnt_q <= perr_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign HIT_FULL      = fifo_full;
  assign HIT_DROP_CNT  = drop_cnt_q;
  assign TOKEN         = token_q;
  assign DATA          = data_q;
  assign BUSY          = busy_q;
  assign PROTO_ERR_CNT = perr_cnt_q;
  assign DBG_STATE     = state_q;

endmodule

// File: tb/tb_tjmono_direct_tx_emu.sv
// Directed and randomized bench for the direct-readout transmitter emulator,
// with a queue-based model of buffered hits and protocol counters.
module tb_tjmono_direct_tx_emu;
  import tjmono_direct_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = 16;

  // Clock / reset
  logic          CLK = 1'b0;
  logic          RESETB = 1'b0;
  logic [31:0]   HIT_DATA = '0;
  logic          HIT_WE = 1'b0;
  logic          HIT_FULL;
  logic [CW-1:0] HIT_DROP_CNT;
  logic          FREEZE = 1'b0;
  logic          READ = 1'b0;
  logic          TOKEN;
  logic          DATA;
  logic          BUSY;
  logic [CW-1:0] PROTO_ERR_CNT;
  state_e        DBG_STATE;

  always #5 CLK = ~CLK;

  tjmono_direct_tx_emu #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .CLK           (CLK),
    .RESETB        (RESETB),
    .HIT_DATA      (HIT_DATA),
    .HIT_WE        (HIT_WE),
    .HIT_FULL      (HIT_FULL),
    .HIT_DROP_CNT  (HIT_DROP_CNT),
    .FREEZE        (FREEZE),
    .READ          (READ),
    .TOKEN         (TOKEN),
    .DATA          (DATA),
    .BUSY          (BUSY),
    .PROTO_ERR_CNT (PROTO_ERR_CNT),
    .DBG_STATE     (DBG_STATE)
  );

  // Scoreboard / model
  logic [31:0] exp_q[$];
  int          drop_exp = 0;
  int          perr_exp = 0;
  int          n_pass = 0;
  int          n_checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESETB = 1'b0; FREEZE = 1'b0; READ = 1'b0; HIT_WE = 1'b0;
    tick();
    RESETB = 1'b1;
    exp_q.delete();
    drop_exp = 0;
    perr_exp = 0;
  endtask

  task automatic write_hit(input logic [31:0] w);
    HIT_DATA = w; HIT_WE = 1'b1;
    tick();
    HIT_WE = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else drop_exp++;
  endtask

  // Issues an accepted READ and collects the serial word; optional READ/FREEZE
  // disturbances at a given bit-cycle, and an optional same-edge write.
  task automatic shift_out(input logic [31:0] exp, input string tag, input int read_at,
                           input int unfrz_at, input bit wr, input logic [31:0] wdat,
                           output logic tok_first);
    logic [31:0] got;
    int busy_n;
    busy_n = 0;
    got = '0;
    READ = 1'b1;
    if (wr) begin HIT_DATA = wdat; HIT_WE = 1'b1; end
    tick();
    READ = 1'b0; HIT_WE = 1'b0;
    tok_first = TOKEN;
    for (int k = 0; k < 32; k++) begin
      got[31-k] = DATA;
      if (BUSY) busy_n++;
      if (k == read_at) READ = 1'b1;
      if (k == unfrz_at) FREEZE = 1'b0;
      tick();
      READ = 1'b0;
    end
    check({tag, "_word"}, got, exp);
    check({tag, "_busy_cycles"}, busy_n, 32);
    check({tag, "_busy_end"}, BUSY, 1'b0);
    check({tag, "_data_end"}, DATA, 1'b0);
  endtask

  logic tok;
  int   rx_cnt;
  int   sent;
  int   batch;

  initial begin
    // Reset state
    RESETB = 1'b0;
    tick(); tick();
    RESETB = 1'b1;
    check("rst_token", TOKEN, 1'b0);
    check("rst_data", DATA, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_full", HIT_FULL, 1'b0);
    check("rst_drop", HIT_DROP_CNT, 0);
    check("rst_perr", PROTO_ERR_CNT, 0);

    // 1: reset mid-shift with words queued
    write_hit(32'h1111_1111); write_hit(32'h2222_2222); write_hit(32'h3333_3333);
    READ = 1'b1; tick(); READ = 1'b0; perr_exp++;
    check("t1_perr_idle", PROTO_ERR_CNT, perr_exp);
    FREEZE = 1'b1; tick();
    READ = 1'b1; tick(); READ = 1'b0;
    repeat (5) tick();
    check("t1_busy_mid", BUSY, 1'b1);
    RESETB = 1'b0; tick(); RESETB = 1'b1;
    exp_q.delete(); drop_exp = 0; perr_exp = 0;
    check("t1_token", TOKEN, 1'b0);
    check("t1_data", DATA, 1'b0);
    check("t1_busy", BUSY, 1'b0);
    check("t1_full", HIT_FULL, 1'b0);
    check("t1_drop", HIT_DROP_CNT, 0);
    check("t1_perr", PROTO_ERR_CNT, 0);
    check("t1_state", DBG_STATE, IDLE);
    tick(); tick();
    check("t1_frz_token", TOKEN, 1'b0);
    READ = 1'b1; tick(); READ = 1'b0; perr_exp++;
    check("t1_frz0_data", DATA, 1'b0);
    check("t1_frz0_busy", BUSY, 1'b0);
    check("t1_frz0_perr", PROTO_ERR_CNT, perr_exp);
    FREEZE = 1'b0; tick();

    // 2: single word, MSB-first pattern and TOKEN timing
    write_hit(32'hA5C3_0F81);
    tick();
    check("t2_token_up", TOKEN, 1'b1);
    FREEZE = 1'b1; tick();
    shift_out(exp_q.pop_front(), "t2", -1, -1, 1'b0, '0, tok);
    check("t2_token_drop", tok, 1'b0);
    FREEZE = 1'b0; tick();

    // 3: snapshot excludes a word written while frozen
    do_reset();
    write_hit(32'hC0DE_0001); write_hit(32'hC0DE_0002); write_hit(32'hC0DE_0003);
    FREEZE = 1'b1; tick();
    write_hit(32'hC0DE_0004);
    for (int i = 0; i < 3; i++) shift_out(exp_q.pop_front(), $sformatf("t3_%0d", i), -1, -1, 1'b0, '0, tok);
    READ = 1'b1; tick(); READ = 1'b0; perr_exp++;
    check("t3_ign_data", DATA, 1'b0);
    check("t3_ign_busy", BUSY, 1'b0);
    check("t3_perr", PROTO_ERR_CNT, perr_exp);
    FREEZE = 1'b0; tick(); tick();
    check("t3_state", DBG_STATE, IDLE);
    check("t3_token_pending", TOKEN, 1'b1);

    // 4: overflow, drop counting, write+pop while full
    do_reset();
    for (int i = 1; i <= 18; i++) begin
      write_hit(32'hF000_0000 | i);
      if (i == 15) check("t4_full_15", HIT_FULL, 1'b0);
      if (i == 16) check("t4_full_16", HIT_FULL, 1'b1);
    end
    check("t4_drop2", HIT_DROP_CNT, drop_exp);
    FREEZE = 1'b1; tick();
    drop_exp++;
    shift_out(exp_q.pop_front(), "t4", -1, -1, 1'b1, 32'hDEAD_BEEF, tok);
    check("t4_drop3", HIT_DROP_CNT, drop_exp);
    check("t4_full_after", HIT_FULL, 1'b0);

    // 5: READ and FREEZE fall during a shift
    perr_exp++;
    shift_out(exp_q.pop_front(), "t5", 10, 20, 1'b0, '0, tok);
    check("t5_perr", PROTO_ERR_CNT, perr_exp);
    check("t5_state", DBG_STATE, IDLE);

    // 6: randomized loopback against a receiver-like driver
    do_reset();
    sent = 0;
    rx_cnt = 0;
    while (sent < 100) begin
      batch = $urandom_range(1, 8);
      if (batch > 100 - sent) batch = 100 - sent;
      for (int i = 0; i < batch; i++) begin
        write_hit($urandom);
        sent++;
        repeat ($urandom_range(0, 2)) tick();
      end
      for (int g = 0; g < 10 && !TOKEN; g++) tick();
      check("t6_token_wait", TOKEN, 1'b1);
      FREEZE = 1'b1; tick();
      while (TOKEN && exp_q.size() > 0) begin
        shift_out(exp_q.pop_front(), "t6", -1, -1, 1'b0, '0, tok);
        rx_cnt++;
      end
      check("t6_drained", exp_q.size(), 0);
      FREEZE = 1'b0; tick();
    end
    check("t6_rx_count", rx_cnt, 100);
    check("t6_drop", HIT_DROP_CNT, 0);
    check("t6_perr", PROTO_ERR_CNT, 0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
